seq_alu: RTL

- Parametrised, registered successor to the combinational 8-bit ALU.
- Arbitrary WIDTH; valid/ready handshake on input and output; signed-overflow and error flags.
- Adds shift ops and a multi-cycle unsigned shift-add multiply.
- Sits between the datapath register file and writeback; one operation in flight at a time.

---
 rtl/seq_alu.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with valid/ready handshake and shift-add multiply
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state, state_next;
    logic                 accept;
    logic [2*WIDTH-1:0]   acc, mcand, acc_next;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     res, sum, diff;
    logic [SHW-1:0]       sh;
    logic                 res_ovf, res_err;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = (op == 3'd3) ? MUL : DONE;
                end
            end
            MUL:     if (cnt == CW'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle ops are computed straight from the inputs on the accept edge.
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        sh      = b[SHW-1:0];
        res     = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: begin
                res     = sum;
                res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'd3: res = '0;
            3'd4: res = a << sh;
            3'd5: res = $unsigned($signed(a) >>> sh);
            3'd6: begin
                res     = diff;
                res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'd7: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                res     = '0;
                res_err = 1'b1;
            end
        endcase
    end

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            z      <= '0;
            zero   <= 1'b1;
            ovf    <= 1'b0;
            err    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (op == 3'd3) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    cnt    <= CW'(WIDTH);
                end else begin
                    z    <= res;
                    zero <= (res == '0);
                    ovf  <= res_ovf;
                    err  <= res_err;
                end
            end
            if (state == MUL) begin
                acc    <= acc_next;
                mplier <= mplier >> 1;
                mcand  <= mcand << 1;
                cnt    <= cnt - CW'(1);
                // Last iteration publishes the product on the edge that enters DONE.
                if (cnt == CW'(1)) begin
                    z    <= acc_next[WIDTH-1:0];
                    zero <= (acc_next[WIDTH-1:0] == '0);
                    ovf  <= |acc_next[2*WIDTH-1:WIDTH];
                    err  <= 1'b0;
                end
            end
        end
    end

endmodule
